// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL gain scheduler: state encodings, default widths
// and the saturating phase-error magnitude helper.
package adpll_pkg;

    localparam int PDET_WIDTH_DEF = 6;
    localparam int KP_WIDTH_DEF   = 8;
    localparam int KI_WIDTH_DEF   = 10;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_ACQUIRE = 2'd2;
    localparam logic [1:0] ST_TRACK   = 2'd3;

    // RAMP needs its own internal code but reports the TRACK encoding externally.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_ACQUIRE = 3'd2,
        S_TRACK   = 3'd3,
        S_RAMP    = 3'd4
    } state_t;

    function automatic logic [1:0] state_code(input state_t s);
        logic [2:0] raw;
        raw = s;
        if (s == S_RAMP) return ST_TRACK;
        return raw[1:0];
    endfunction

    // The most negative sample has no positive twin, so it clamps to the largest magnitude.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] err, input int width);
        logic signed [31:0] most_neg;
        most_neg = -(32'sd1 <<< (width - 1));
        if (err == most_neg) return (32'd1 << (width - 1)) - 32'd1;
        if (err < 0) return 32'(-err);
        return 32'(err);
    endfunction

endpackage

// File: rtl/adpll_window_counter.sv
// Saturating consecutive-sample counter; done flags the sample that reaches TERMINAL.
module adpll_window_counter #(
    parameter int TERMINAL = 16,
    parameter int CW       = $clog2(TERMINAL) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_valid,
    input  logic          in_window,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          done
);

    localparam logic [CW-1:0] TERM      = CW'(TERMINAL);
    localparam logic [CW-1:0] TERM_LAST = CW'(TERMINAL - 1);

    assign done = sample_valid && in_window && (count >= TERM_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (sample_valid) begin
            if (!in_window) begin
                count <= '0;
            end else if (count != TERM) begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/adpll_gain_scheduler.sv
// Sequences one ring ADPLL node IDLE -> SETTLE -> ACQUIRE -> TRACK and schedules KP/KI.
// Optional GAIN_RAMP_EN inserts a RAMP state that walks the gains to their track values.
module adpll_gain_scheduler
    import adpll_pkg::*;
#(
    parameter int PDET_WIDTH    = PDET_WIDTH_DEF,
    parameter int KP_WIDTH      = KP_WIDTH_DEF,
    parameter int KI_WIDTH      = KI_WIDTH_DEF,
    parameter int SETTLE_CYCLES = 256,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_COUNT  = 4,
    parameter int LOCK_WINDOW   = 2
) (
    input  logic                  fpga_clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic [PDET_WIDTH-1:0] error_i,
    input  logic                  error_valid_i,
    input  logic [KP_WIDTH-1:0]   kp_acq_i,
    input  logic [KI_WIDTH-1:0]   ki_acq_i,
    input  logic [KP_WIDTH-1:0]   kp_trk_i,
    input  logic [KI_WIDTH-1:0]   ki_trk_i,
    output logic                  node_enable_o,
    output logic [KP_WIDTH-1:0]   kp_o,
    output logic [KI_WIDTH-1:0]   ki_o,
    output logic                  locked_o,
    output logic                  lock_lost_o,
    output logic [1:0]            state_o
);

    localparam int SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int LW = $clog2(LOCK_COUNT) + 1;
    localparam int UW = $clog2(UNLOCK_COUNT) + 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_t                state, next_state;
    logic [SW-1:0]         settle_cnt;
    logic [PDET_WIDTH-1:0] err_mag;
    logic                  in_window;
    logic                  lock_done, unlock_done;
    logic                  lock_clear, unlock_clear;
    logic [LW-1:0]         lock_cnt;
    logic [UW-1:0]         unlock_cnt;
    logic [KP_WIDTH-1:0]   kp_nxt;
    logic [KI_WIDTH-1:0]   ki_nxt;
    logic                  cnt_unused;

    assign err_mag   = PDET_WIDTH'(abs_sat(32'(signed'(error_i)), PDET_WIDTH));
    assign in_window = (err_mag <= PDET_WIDTH'(LOCK_WINDOW));

    assign lock_clear   = (state != S_ACQUIRE) || (next_state != S_ACQUIRE);
    assign unlock_clear = (state != S_TRACK)   || (next_state != S_TRACK);
    assign cnt_unused   = ^{lock_cnt, unlock_cnt};

    adpll_window_counter #(.TERMINAL(LOCK_COUNT), .CW(LW)) u_lock_cnt (
        .clk          (fpga_clk_i),
        .rst          (reset_i),
        .sample_valid (error_valid_i),
        .in_window    (in_window),
        .clear        (lock_clear),
        .count        (lock_cnt),
        .done         (lock_done)
    );

    // Same counter reused for misses: an in-window sample breaks the run.
    adpll_window_counter #(.TERMINAL(UNLOCK_COUNT), .CW(UW)) u_unlock_cnt (
        .clk          (fpga_clk_i),
        .rst          (reset_i),
        .sample_valid (error_valid_i),
        .in_window    (!in_window),
        .clear        (unlock_clear),
        .count        (unlock_cnt),
        .done         (unlock_done)
    );

    always_comb begin
        next_state = state;
        kp_nxt     = '0;
        ki_nxt     = '0;
        if (!enable_i) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    next_state = S_SETTLE;
                S_SETTLE:  if (settle_cnt == SETTLE_LAST) next_state = S_ACQUIRE;
`ifdef GAIN_RAMP_EN
                S_ACQUIRE: if (lock_done) next_state = S_RAMP;
                S_RAMP: begin
                    if (error_valid_i && !in_window)
                        next_state = S_ACQUIRE;
                    else if (kp_o == kp_trk_i && ki_o == ki_trk_i)
                        next_state = S_TRACK;
                end
`else
                S_ACQUIRE: if (lock_done) next_state = S_TRACK;
`endif
                S_TRACK:   if (unlock_done) next_state = S_ACQUIRE;
                default:   next_state = S_IDLE;
            endcase
        end

        case (next_state)
            S_SETTLE, S_ACQUIRE: begin
                kp_nxt = kp_acq_i;
                ki_nxt = ki_acq_i;
            end
            S_TRACK: begin
                kp_nxt = kp_trk_i;
                ki_nxt = ki_trk_i;
            end
`ifdef GAIN_RAMP_EN
            S_RAMP: begin
                kp_nxt = kp_o;
                ki_nxt = ki_o;
                if (state == S_RAMP && error_valid_i) begin
                    if (kp_o < kp_trk_i)      kp_nxt = kp_o + KP_WIDTH'(1);
                    else if (kp_o > kp_trk_i) kp_nxt = kp_o - KP_WIDTH'(1);
                    if (ki_o < ki_trk_i)      ki_nxt = ki_o + KI_WIDTH'(1);
                    else if (ki_o > ki_trk_i) ki_nxt = ki_o - KI_WIDTH'(1);
                end
            end
`endif
            default: begin
                kp_nxt = '0;
                ki_nxt = '0;
            end
        endcase
    end

    // Every output is registered from the next-state decode so they all move together.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= S_IDLE;
            settle_cnt    <= '0;
            node_enable_o <= 1'b0;
            kp_o          <= '0;
            ki_o          <= '0;
            locked_o      <= 1'b0;
            lock_lost_o   <= 1'b0;
            state_o       <= ST_IDLE;
        end else begin
            state         <= next_state;
            node_enable_o <= (next_state != S_IDLE);
            kp_o          <= kp_nxt;
            ki_o          <= ki_nxt;
            locked_o      <= (next_state == S_TRACK);
            state_o       <= state_code(next_state);
            if (state == S_TRACK && next_state == S_ACQUIRE)
                lock_lost_o <= 1'b1;
            if (state == S_SETTLE && next_state == S_SETTLE) begin
                if (settle_cnt != SW'(SETTLE_CYCLES))
                    settle_cnt <= settle_cnt + SW'(1);
            end else begin
                settle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_adpll_gain_scheduler.sv
// Directed self-checking bench for adpll_gain_scheduler (default build, GAIN_RAMP_EN undefined).
module tb_adpll_gain_scheduler;

    logic       fpga_clk_i;
    logic       reset_i;
    logic       enable_i;
    logic [5:0] error_i;
    logic       error_valid_i;
    logic [7:0] kp_acq_i, kp_trk_i, kp_o;
    logic [9:0] ki_acq_i, ki_trk_i, ki_o;
    logic       node_enable_o, locked_o, lock_lost_o;
    logic [1:0] state_o;

    int test_count = 0;
    int fail_count = 0;

    localparam logic [7:0] KP_ACQ = 8'h20;
    localparam logic [7:0] KP_TRK = 8'h04;
    localparam logic [9:0] KI_ACQ = 10'h100;
    localparam logic [9:0] KI_TRK = 10'h010;

    adpll_gain_scheduler dut (
        .fpga_clk_i    (fpga_clk_i),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .error_i       (error_i),
        .error_valid_i (error_valid_i),
        .kp_acq_i      (kp_acq_i),
        .ki_acq_i      (ki_acq_i),
        .kp_trk_i      (kp_trk_i),
        .ki_trk_i      (ki_trk_i),
        .node_enable_o (node_enable_o),
        .kp_o          (kp_o),
        .ki_o          (ki_o),
        .locked_o      (locked_o),
        .lock_lost_o   (lock_lost_o),
        .state_o       (state_o)
    );

    initial begin
        fpga_clk_i = 1'b0;
        forever #5 fpga_clk_i = ~fpga_clk_i;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic [1:0] st, input logic ne,
                              input logic [7:0] kp, input logic [9:0] ki,
                              input logic lk, input logic lost);
        checkOutput({tag, ".state"}, 32'(state_o), 32'(st));
        checkOutput({tag, ".node_en"}, 32'(node_enable_o), 32'(ne));
        checkOutput({tag, ".kp"}, 32'(kp_o), 32'(kp));
        checkOutput({tag, ".ki"}, 32'(ki_o), 32'(ki));
        checkOutput({tag, ".locked"}, 32'(locked_o), 32'(lk));
        checkOutput({tag, ".lost"}, 32'(lock_lost_o), 32'(lost));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge fpga_clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] err);
        error_i       = err;
        error_valid_i = 1'b1;
        tick(1);
        error_valid_i = 1'b0;
    endtask

    task automatic strobeRun(input int n, input logic [5:0] err);
        for (int i = 0; i < n; i++) applyStimulus(err);
    endtask

    task automatic enterAcquire();
        enable_i = 1'b1;
        tick(1);
        checkState("settle_entry", 2'd1, 1'b1, KP_ACQ, KI_ACQ, 1'b0, lock_lost_o);
        // Strobes during SETTLE must not pre-load the lock counter.
        error_i       = 6'd0;
        error_valid_i = 1'b1;
        tick(255);
        checkOutput("settle_hold.state", 32'(state_o), 32'd1);
        tick(1);
        error_valid_i = 1'b0;
        checkOutput("acquire_entry.state", 32'(state_o), 32'd2);
    endtask

    logic [5:0] win_vals [5];

    initial begin
        win_vals      = '{6'd1, 6'h3F, 6'd2, 6'h3E, 6'd0};
        reset_i       = 1'b1;
        enable_i      = 1'b0;
        error_i       = '0;
        error_valid_i = 1'b0;
        kp_acq_i      = KP_ACQ;
        ki_acq_i      = KI_ACQ;
        kp_trk_i      = KP_TRK;
        ki_trk_i      = KI_TRK;
        tick(2);
        reset_i = 1'b0;
        checkState("reset", 2'd0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0);
        tick(2);
        checkState("idle", 2'd0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0);

        enterAcquire();

        // Lock window: an out-of-window +3 restarts the run.
        strobeRun(15, 6'd1);
        checkOutput("win15.state", 32'(state_o), 32'd2);
        applyStimulus(6'd3);
        checkOutput("win_plus3.state", 32'(state_o), 32'd2);
        for (int i = 0; i < 15; i++) applyStimulus(win_vals[i % 5]);
        checkState("win_restart15", 2'd2, 1'b1, KP_ACQ, KI_ACQ, 1'b0, 1'b0);
        applyStimulus(6'h3E);
        checkState("lock", 2'd3, 1'b1, KP_TRK, KI_TRK, 1'b1, 1'b0);

        kp_trk_i = 8'h05;
        ki_trk_i = 10'h011;
        tick(1);
        checkOutput("trk_gain_follow.kp", 32'(kp_o), 32'h05);
        checkOutput("trk_gain_follow.ki", 32'(ki_o), 32'h011);
        kp_trk_i = KP_TRK;
        ki_trk_i = KI_TRK;
        tick(1);

        // Unlock: a single in-window sample breaks the miss run.
        strobeRun(3, 6'h3B);
        checkOutput("miss3.state", 32'(state_o), 32'd3);
        applyStimulus(6'd0);
        strobeRun(3, 6'h3B);
        checkOutput("miss3b.state", 32'(state_o), 32'd3);
        checkOutput("miss3b.locked", 32'(locked_o), 32'd1);
        applyStimulus(6'h20);
        checkState("unlock", 2'd2, 1'b1, KP_ACQ, KI_ACQ, 1'b0, 1'b1);

        // Relock with +1 samples; the sticky flag survives.
        strobeRun(15, 6'd1);
        checkOutput("relock15.state", 32'(state_o), 32'd2);
        applyStimulus(6'd1);
        checkState("relock", 2'd3, 1'b1, KP_TRK, KI_TRK, 1'b1, 1'b1);

        // Asynchronous reset between clock edges.
        #3;
        reset_i = 1'b1;
        #1;
        checkState("async_reset", 2'd0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0);
        @(posedge fpga_clk_i);
        #1;
        reset_i = 1'b0;

        // Disable wins over the lock-completing strobe.
        enterAcquire();
        strobeRun(15, 6'd1);
        enable_i = 1'b0;
        applyStimulus(6'd1);
        checkState("disable_prio", 2'd0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0);
        tick(2);
        checkState("disable_hold", 2'd0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
